powlib_sfifo_cnt: RTL and testbench



---
 rtl/powlib_sfifo_cnt_pkg.sv | 9 +
 rtl/powlib_dpram.sv | 26 ++
 rtl/powlib_modcntr.sv | 34 +++
 rtl/powlib_sfifo_cnt.sv | 115 +++++++++++
 tb/tb_powlib_sfifo_cnt.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/powlib_sfifo_cnt_pkg.sv
// rtl/powlib_sfifo_cnt_pkg.sv - shared sizing helper for the counted single-clock FIFO
package powlib_sfifo_cnt_pkg;

    // Bits needed to index n distinct values; never less than one bit.
    function automatic int clogb2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/powlib_dpram.sv
// rtl/powlib_dpram.sv - D x W storage, synchronous write, asynchronous read
module powlib_dpram
    import powlib_sfifo_cnt_pkg::*;
#(
    parameter int W = 16,
    parameter int D = 8
) (
    input  logic                  clk,
    input  logic                  wrvld,
    input  logic [clogb2(D)-1:0]  wridx,
    input  logic [W-1:0]          wrdata,
    input  logic [clogb2(D)-1:0]  rdidx,
    output logic [W-1:0]          rddata
);

    logic [W-1:0] mem [D];

    always_ff @(posedge clk) begin
        if (wrvld) begin
            mem[wridx] <= wrdata;
        end
    end

    assign rddata = mem[rdidx];

endmodule

// File: rtl/powlib_modcntr.sv
// rtl/powlib_modcntr.sv - modulo-MOD counter used as a FIFO pointer
module powlib_modcntr #(
    parameter int W   = 3,
    parameter int MOD = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    input  logic         clr,
    output logic [W-1:0] cntr
);

    logic [W-1:0] cntr_q, cntr_d;

    always_comb begin
        cntr_d = cntr_q;
        if (clr) begin
            cntr_d = '0;
        end else if (adv) begin
            cntr_d = (cntr_q == W'(MOD - 1)) ? '0 : cntr_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cntr_q <= '0;
        end else begin
            cntr_q <= cntr_d;
        end
    end

    assign cntr = cntr_q;

endmodule

// File: rtl/powlib_sfifo_cnt.sv
// rtl/powlib_sfifo_cnt.sv - single-clock FIFO with occupancy count, almost flags, flush and sticky errors
module powlib_sfifo_cnt
    import powlib_sfifo_cnt_pkg::*;
#(
    parameter int    W    = 16,
    parameter int    D    = 8,
    parameter int    AFT  = D - 2,
    parameter int    AET  = 1,
    parameter int    EDBG = 0,
    parameter string ID   = "SFIFOCNT"
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic [W-1:0]            wrdata,
    input  logic                    wrvld,
    output logic                    wrrdy,
    output logic [W-1:0]            rddata,
    output logic                    rdvld,
    input  logic                    rdrdy,
    output logic [clogb2(D+1)-1:0]  cnt,
    output logic                    afull,
    output logic                    aempty,
    output logic                    ovf,
    output logic                    unf
);

    localparam int PW = clogb2(D);
    localparam int CW = clogb2(D + 1);

    if (D < 2) begin : g_bad_d
        $fatal(1, "%s: D=%0d must be >= 2", ID, D);
    end
    if (AFT < 1 || AFT > D) begin : g_bad_aft
        $fatal(1, "%s: AFT=%0d outside 1..%0d", ID, AFT, D);
    end
    if (AET < 0 || AET > D - 1) begin : g_bad_aet
        $fatal(1, "%s: AET=%0d outside 0..%0d", ID, AET, D - 1);
    end
    if (EDBG != 0 && EDBG != 1) begin : g_bad_edbg
        $fatal(1, "%s: EDBG=%0d must be 0 or 1", ID, EDBG);
    end

    logic [PW-1:0] wrptr, rdptr;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic          full, empty, wrinc, rdinc;

    // Readiness comes only from registered count, so there is no pass-through when full.
    always_comb begin
        full   = (cnt_q == CW'(D));
        empty  = (cnt_q == '0);
        wrrdy  = ~full & ~clr;
        rdvld  = ~empty & ~clr;
        wrinc  = wrvld & wrrdy;
        rdinc  = rdvld & rdrdy;
        afull  = (cnt_q >= CW'(AFT)) & ~clr;
        aempty = (cnt_q <= CW'(AET));
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (wrinc && !rdinc) begin
            cnt_d = cnt_q + CW'(1);
        end else if (rdinc && !wrinc) begin
            cnt_d = cnt_q - CW'(1);
        end
        ovf_d = ovf_q | (wrvld & ~wrrdy & full);
        unf_d = unf_q | (rdrdy & ~rdvld);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;
    assign unf = unf_q;

    powlib_modcntr #(.W(PW), .MOD(D)) u_wrptr (
        .clk  (clk),
        .rst  (rst),
        .adv  (wrinc),
        .clr  (clr),
        .cntr (wrptr)
    );

    powlib_modcntr #(.W(PW), .MOD(D)) u_rdptr (
        .clk  (clk),
        .rst  (rst),
        .adv  (rdinc),
        .clr  (clr),
        .cntr (rdptr)
    );

    powlib_dpram #(.W(W), .D(D)) u_ram (
        .clk    (clk),
        .wrvld  (wrinc),
        .wridx  (wrptr),
        .wrdata (wrdata),
        .rdidx  (rdptr),
        .rddata (rddata)
    );

endmodule

// File: tb/tb_powlib_sfifo_cnt.sv
// tb/tb_powlib_sfifo_cnt.sv - directed vector bench for powlib_sfifo_cnt at D=5, W=8
module tb_powlib_sfifo_cnt;

    localparam int W  = 8;
    localparam int D  = 5;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst, clr, wrvld, rdrdy;
    logic [W-1:0]  wrdata, rddata;
    logic          wrrdy, rdvld, afull, aempty, ovf, unf;
    logic [CW-1:0] cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    powlib_sfifo_cnt #(.W(W), .D(D)) dut (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .wrdata (wrdata),
        .wrvld  (wrvld),
        .wrrdy  (wrrdy),
        .rddata (rddata),
        .rdvld  (rdvld),
        .rdrdy  (rdrdy),
        .cnt    (cnt),
        .afull  (afull),
        .aempty (aempty),
        .ovf    (ovf),
        .unf    (unf)
    );

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       rr;
        logic [2:0] cnt;
        logic       wrdy;
        logic       rvld;
        logic       af;
        logic       ae;
        logic       dchk;
        logic [7:0] rd;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   q[$];
        int   mc;
        int   k;
        logic do_wr, do_rd;

        rst = 1'b1; clr = 1'b0; wrvld = 1'b0; rdrdy = 1'b0; wrdata = '0;
        #3;
        chk("rst_cnt", cnt, 0);
        chk("rst_wrrdy", wrrdy, 1);
        chk("rst_rdvld", rdvld, 0);
        chk("rst_afull", afull, 0);
        chk("rst_aempty", aempty, 1);
        chk("rst_ovf", ovf, 0);
        chk("rst_unf", unf, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // fill with 0x11..0x55, then drain; outputs are those seen before each edge
        vt[0]  = '{1'b1, 8'h11, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        vt[1]  = '{1'b1, 8'h22, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11};
        vt[2]  = '{1'b1, 8'h33, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11};
        vt[3]  = '{1'b1, 8'h44, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11};
        vt[4]  = '{1'b1, 8'h55, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11};
        vt[5]  = '{1'b0, 8'h00, 1'b0, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11};
        vt[6]  = '{1'b0, 8'h00, 1'b1, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11};
        vt[7]  = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22};
        vt[8]  = '{1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33};
        vt[9]  = '{1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h44};
        vt[10] = '{1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55};
        vt[11] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};

        for (int i = 0; i < 12; i++) begin
            wrvld = vt[i].wv; wrdata = vt[i].wd; rdrdy = vt[i].rr;
            #1;
            chk($sformatf("v%0d_cnt", i), cnt, vt[i].cnt);
            chk($sformatf("v%0d_wrrdy", i), wrrdy, vt[i].wrdy);
            chk($sformatf("v%0d_rdvld", i), rdvld, vt[i].rvld);
            chk($sformatf("v%0d_afull", i), afull, vt[i].af);
            chk($sformatf("v%0d_aempty", i), aempty, vt[i].ae);
            if (vt[i].dchk) chk($sformatf("v%0d_rddata", i), rddata, vt[i].rd);
            tick();
        end
        wrvld = 1'b0; rdrdy = 1'b0;
        chk("fill_ovf", ovf, 0);
        chk("fill_unf", unf, 0);

        // interleaved traffic holding occupancy at 2..3 across pointer wrap
        mc = 0; k = 0;
        for (int c = 0; c < 24; c++) begin
            if (c < 2)        begin do_wr = 1'b1; do_rd = 1'b0; end
            else if (c < 22)  begin do_wr = (c % 2 == 0); do_rd = (c % 2 == 1); end
            else              begin do_wr = 1'b0; do_rd = 1'b1; end
            wrvld = do_wr; rdrdy = do_rd; wrdata = 8'h60 + 8'(k);
            #1;
            chk($sformatf("wrap%0d_cnt", c), cnt, mc);
            if (cnt > 3) chk($sformatf("wrap%0d_cnt_le3", c), cnt, 3);
            if (do_rd) begin
                chk($sformatf("wrap%0d_rddata", c), rddata, q[0]);
                q.pop_front();
                mc--;
            end
            if (do_wr) begin
                q.push_back(32'h60 + k);
                k++;
                mc++;
            end
            tick();
        end
        wrvld = 1'b0; rdrdy = 1'b0;
        chk("wrap_writes", k, 12);
        chk("wrap_empty", cnt, 0);

        // full with simultaneous write and read
        for (int i = 1; i <= 5; i++) begin
            wrvld = 1'b1; wrdata = 8'hC0 + 8'(i);
            tick();
        end
        wrdata = 8'hC6; wrvld = 1'b1; rdrdy = 1'b1;
        #1;
        chk("full_wrrdy", wrrdy, 0);
        chk("full_rdvld", rdvld, 1);
        chk("full_rddata", rddata, 8'hC1);
        chk("full_ovf_pre", ovf, 0);
        tick();
        chk("full_rd_cnt", cnt, 4);
        chk("full_ovf_post", ovf, 1);
        chk("both_wrrdy", wrrdy, 1);
        chk("both_rddata", rddata, 8'hC2);
        tick();
        chk("both_cnt", cnt, 4);
        wrvld = 1'b0;
        #1;
        chk("after_rddata", rddata, 8'hC3);
        tick();
        rdrdy = 1'b0;
        #1;
        chk("pre_clr_cnt", cnt, 3);
        chk("pre_clr_unf", unf, 0);

        // synchronous flush with both handshakes requested
        clr = 1'b1; wrvld = 1'b1; wrdata = 8'hEE; rdrdy = 1'b1;
        #1;
        chk("clr_wrrdy", wrrdy, 0);
        chk("clr_rdvld", rdvld, 0);
        chk("clr_afull", afull, 0);
        tick();
        clr = 1'b0; wrvld = 1'b0; rdrdy = 1'b0;
        #1;
        chk("post_clr_cnt", cnt, 0);
        chk("post_clr_rdvld", rdvld, 0);
        wrvld = 1'b1; wrdata = 8'hAB;
        tick();
        wrvld = 1'b0; rdrdy = 1'b1;
        #1;
        chk("ab_rdvld", rdvld, 1);
        chk("ab_rddata", rddata, 8'hAB);
        tick();
        chk("ab_empty_rdvld", rdvld, 0);
        tick();
        rdrdy = 1'b0;
        chk("unf_sticky", unf, 1);
        chk("ovf_sticky", ovf, 1);

        // asynchronous reset in the middle of a burst
        for (int i = 1; i <= 4; i++) begin
            wrvld = 1'b1; wrdata = 8'hD0 + 8'(i);
            tick();
        end
        chk("pre_rst_cnt", cnt, 4);
        wrdata = 8'hD5;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cnt", cnt, 0);
        chk("arst_wrrdy", wrrdy, 1);
        chk("arst_rdvld", rdvld, 0);
        chk("arst_aempty", aempty, 1);
        chk("arst_afull", afull, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_unf", unf, 0);
        wrvld = 1'b0;
        #2;
        rst = 1'b0;
        tick();
        wrvld = 1'b1; wrdata = 8'h77;
        tick();
        wrvld = 1'b0; rdrdy = 1'b1;
        #1;
        chk("resume_cnt", cnt, 1);
        chk("resume_rddata", rddata, 8'h77);
        tick();
        rdrdy = 1'b0;
        chk("resume_empty", cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
